fp_addsub_param: RTL

- Parametrised successor to the team's fixed 32-bit float adder: sign / EXP_W exponent / MAN_W fraction format, configurable at elaboration.
- Performs add or subtract per transaction, with round-to-nearest-even and a valid/ready handshake.
- Fixed-latency multicycle FSM; sits between the operand register file and the result bus of the FP datapath.
- Encoding: value = (-1)^s × 1.f × 2^(e−BIAS), BIAS = 2^(EXP_W−1)−1.
  - e = 0 means zero (no subnormals).
  - e = all-ones means infinity.

---
 rtl/fp_addsub_param.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_param.sv
// Parametrised sign/exponent/fraction floating-point adder-subtractor, round-to-nearest-even,
// fixed six-state pipeline (IDLE, ALIGN, ADD, NORM, ROUND, DONE) behind a valid/ready handshake.
module fp_addsub_param #(
    parameter int EXP_W  = 6,
    parameter int MAN_W  = 25,
    parameter int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clock_100kHz,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] op_A_in,
    input  logic [DATA_W-1:0] op_B_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        status_out,
    output logic [2:0]        o_dbg_state
);

    // Window = hidden bit + fraction + guard + round + sticky; the sum adds one carry bit.
    localparam int WIN_W = MAN_W + 4;
    localparam int SUM_W = WIN_W + 1;
    localparam int LZ_W  = $clog2(WIN_W + 1);
    localparam int ER_W  = (EXP_W + 2 > LZ_W + 2) ? EXP_W + 2 : LZ_W + 2;
    localparam logic [ER_W-1:0] EXP_MAX = ER_W'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_special;
    logic [DATA_W-1:0] r_spec_data;
    logic [3:0]        r_spec_status;
    logic              r_sx;
    logic              r_eff_sub;
    logic [EXP_W-1:0]  r_ex;
    logic [WIN_W-1:0]  r_win_x;
    logic [WIN_W-1:0]  r_win_y;
    logic [SUM_W-1:0]  r_sum;
    logic [WIN_W-1:0]  r_norm;
    logic [ER_W-1:0]   r_exp;
    logic              r_zero;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_status;

    logic              w_sa, w_sb, w_sx, w_a_is_x;
    logic [EXP_W-1:0]  w_ea, w_eb, w_ex, w_ey;
    logic [WIN_W-1:0]  w_x_ext, w_y_ext, w_y_shift, w_y_mask, w_win_y;
    logic [31:0]       w_d;
    logic              w_special;
    logic [DATA_W-1:0] w_spec_data;
    logic [3:0]        w_spec_status;
    logic [LZ_W-1:0]   w_lzc;
    logic              w_up;
    logic [MAN_W+1:0]  w_mant;
    logic [MAN_W-1:0]  w_frac;
    logic [ER_W-1:0]   w_exp_r;
    logic [DATA_W-1:0] w_res_data;
    logic [3:0]        w_res_status;

    // Handshake: a transaction is accepted on a rising edge with in_valid && in_ready, and a result
    // is consumed on a rising edge with out_valid && out_ready; the block holds one transaction at a time.
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign data_out    = r_data;
    assign status_out  = r_status;
    assign o_dbg_state = r_state;

    assign w_sa     = r_a[DATA_W-1];
    assign w_sb     = r_b[DATA_W-1];
    assign w_ea     = r_a[DATA_W-2 -: EXP_W];
    assign w_eb     = r_b[DATA_W-2 -: EXP_W];
    assign w_a_is_x = (r_a[DATA_W-2:0] >= r_b[DATA_W-2:0]);
    assign w_sx     = w_a_is_x ? w_sa : w_sb;
    assign w_ex     = w_a_is_x ? w_ea : w_eb;
    assign w_ey     = w_a_is_x ? w_eb : w_ea;
    assign w_x_ext  = {1'b1, (w_a_is_x ? r_a[MAN_W-1:0] : r_b[MAN_W-1:0]), 3'b000};
    assign w_y_ext  = {1'b1, (w_a_is_x ? r_b[MAN_W-1:0] : r_a[MAN_W-1:0]), 3'b000};
    assign w_d      = 32'(w_ex) - 32'(w_ey);

    // Alignment: everything shifted past the window collapses into the sticky bit.
    always_comb begin
        w_y_mask  = ~({WIN_W{1'b1}} << w_d);
        w_y_shift = w_y_ext >> w_d;
        w_win_y   = '0;
        if (w_d >= 32'(WIN_W)) begin
            w_win_y = {{(WIN_W-1){1'b0}}, 1'b1};
        end else begin
            w_win_y = {w_y_shift[WIN_W-1:1], w_y_shift[0] | (|(w_y_ext & w_y_mask))};
        end
    end

    always_comb begin
        w_special     = 1'b0;
        w_spec_data   = '0;
        w_spec_status = 4'b0000;
        if ((&w_ea) || (&w_eb)) begin
            w_special = 1'b1;
            if ((&w_ea) && (&w_eb) && (w_sa != w_sb)) begin
                w_spec_data   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_spec_status = 4'b1010;
            end else begin
                w_spec_data   = {w_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_spec_status = 4'b0010;
            end
        end else if (w_eb == '0) begin
            w_special     = 1'b1;
            w_spec_data   = r_a;
            w_spec_status = 4'b0001;
        end else if (w_ea == '0) begin
            w_special     = 1'b1;
            w_spec_data   = r_b;
            w_spec_status = 4'b0001;
        end
    end

    // Leading-zero count: the highest set bit is the last one to write.
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < WIN_W; i++) begin
            if (r_sum[i]) w_lzc = LZ_W'(WIN_W - 1 - i);
        end
    end

    always_comb begin
        w_up         = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
        w_mant       = {1'b0, r_norm[WIN_W-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
        w_exp_r      = r_exp + ER_W'(w_mant[MAN_W+1]);
        w_frac       = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
        w_res_data   = '0;
        w_res_status = 4'b0001;
        if (r_special) begin
            w_res_data   = r_spec_data;
            w_res_status = r_spec_status;
        end else if (r_zero) begin
            w_res_data   = '0;
            w_res_status = 4'b0001;
        end else if ($signed(w_exp_r) >= $signed(EXP_MAX)) begin
            w_res_data   = {r_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_res_status = 4'b1010;
        end else if (w_exp_r[ER_W-1] || (w_exp_r == '0)) begin
            w_res_data   = {r_sx, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            w_res_status = 4'b1100;
        end else begin
            w_res_data   = {r_sx, w_exp_r[EXP_W-1:0], w_frac};
            w_res_status = (|r_norm[2:0]) ? 4'b1000 : 4'b0001;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_ALIGN;
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_special     <= 1'b0;
            r_spec_data   <= '0;
            r_spec_status <= '0;
            r_sx          <= 1'b0;
            r_eff_sub     <= 1'b0;
            r_ex          <= '0;
            r_win_x       <= '0;
            r_win_y       <= '0;
            r_sum         <= '0;
            r_norm        <= '0;
            r_exp         <= '0;
            r_zero        <= 1'b0;
            r_data        <= '0;
            r_status      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= op_A_in;
                        r_b <= {op_B_in[DATA_W-1] ^ op_sub, op_B_in[DATA_W-2:0]};
                    end
                end
                S_ALIGN: begin
                    r_special     <= w_special;
                    r_spec_data   <= w_spec_data;
                    r_spec_status <= w_spec_status;
                    r_sx          <= w_sx;
                    r_eff_sub     <= (w_sa != w_sb);
                    r_ex          <= w_ex;
                    r_win_x       <= w_x_ext;
                    r_win_y       <= w_win_y;
                end
                S_ADD: begin
                    r_sum <= r_eff_sub ? ({1'b0, r_win_x} - {1'b0, r_win_y})
                                       : ({1'b0, r_win_x} + {1'b0, r_win_y});
                end
                S_NORM: begin
                    r_zero <= (r_sum == '0);
                    if (r_sum[SUM_W-1]) begin
                        r_norm <= {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
                        r_exp  <= ER_W'(r_ex) + ER_W'(1);
                    end else begin
                        r_norm <= r_sum[WIN_W-1:0] << w_lzc;
                        r_exp  <= ER_W'(r_ex) - ER_W'(w_lzc);
                    end
                end
                S_ROUND: begin
                    r_data   <= w_res_data;
                    r_status <= w_res_status;
                end
                default: ;
            endcase
        end
    end

endmodule
